nf10_axis_pkt_out_queue: RTL and testbench
==========================================

Name: nf10_axis_pkt_out_queue

Overview:
Store-and-forward AXI4-Stream packet queue. It sits directly upstream of the stream recorder / output port and feeds it only complete packets, so the downstream sink never sees a packet stall mid-frame waiting on the source. Packets longer than the queue are dropped and counted; otherwise the queue backpressures.

Parameters:
C_AXIS_DATA_WIDTH, 256, tdata width; tstrb width is C_AXIS_DATA_WIDTH/8.
C_AXIS_TUSER_WIDTH, 128, tuser width; stored per beat.
C_DEPTH_LOG2, 5, log2 of beat storage (32 beats).
C_PKTS_LOG2, 4, width of the committed-packet counter (max 2^C_PKTS_LOG2 - 1 committed packets).

Ports:
aclk  in  1  clock; all logic is on the rising edge.
aresetn  in  1  asynchronous active-low reset.
s_axis_tdata  in  C_AXIS_DATA_WIDTH  input beat data.
s_axis_tstrb  in  C_AXIS_DATA_WIDTH/8  byte strobes.
s_axis_tuser  in  C_AXIS_TUSER_WIDTH  sideband.
s_axis_tvalid  in  1  input valid.
s_axis_tready  out  1  input ready.
s_axis_tlast  in  1  last beat of packet.
m_axis_tdata  out  C_AXIS_DATA_WIDTH  output data.
m_axis_tstrb  out  C_AXIS_DATA_WIDTH/8  output strobes.
m_axis_tuser  out  C_AXIS_TUSER_WIDTH  output sideband.
m_axis_tvalid  out  1  output valid.
m_axis_tready  in  1  output ready.
m_axis_tlast  out  1  output last.
pkt_count  out  8  packets fully forwarded (tlast handshake on m_axis); wraps 255->0.
drop_count  out  8  oversize packets dropped; wraps 255->0.

Behaviour:
- Reset (aresetn=0, asynchronous): wr_ptr, rd_ptr, pkt_start_ptr, committed count, state cleared. m_axis_tvalid=0, s_axis_tready=0, pkt_count=0, drop_count=0. A partial packet in flight is lost. After release, s_axis_tready=1 from the first cycle.
- Storage: 2^C_DEPTH_LOG2 beats of {tdata, tstrb, tuser, tlast}. Pointers are C_DEPTH_LOG2+1 bits; full/empty use the MSB-compare rule.
- Write FSM, state ACCEPT:
  - s_axis_tready = !full.
  - Each handshake writes one beat and increments wr_ptr.
  - A handshake with tlast commits the packet: committed+1 on that edge, and pkt_start_ptr<=wr_ptr+1.
- ACCEPT->DROP: full and committed==0 (the current partial packet occupies the whole queue). Cannot complete, so it is dropped.
- DROP:
  - s_axis_tready=1; beats are discarded.
  - On the tlast handshake: wr_ptr<=pkt_start_ptr (rollback), drop_count+1, return to ACCEPT.
  - If the packet being dropped ends on the beat that filled the queue, it is committed normally, not dropped.
- Backpressure: full with committed>0 holds s_axis_tready=0 in ACCEPT.
- Committed-counter saturation: if committed == 2^C_PKTS_LOG2-1 and the incoming beat carries tlast, s_axis_tready=0 for that beat.
- Read side:
  - Reads come only from the committed region.
  - The output register holds one beat; the next beat is prefetched so sustained throughput is 1 beat/cycle, including back-to-back across packet boundaries when the next packet is already committed.
  - Latency: tlast accepted at edge N, committed visible at N+1, m_axis_tvalid=1 with beat 0 after edge N+2 (idle output).
- m_axis handshake: once tvalid=1, tdata/tstrb/tuser/tlast stay stable until tready=1. Tvalid never deasserts within a packet.
- On the m_axis tlast handshake: committed-1 and pkt_count+1.
- Simultaneous commit (write tlast) and release (read tlast) in one cycle: committed is unchanged.
- Rollback never touches committed beats. A simultaneous read is unaffected.
- Single-beat packets (tvalid with tlast) are legal and follow the same rules.
- tstrb and tuser pass through unmodified. No byte manipulation.

Test Plan:
- Reset, then one 4-beat packet, m_axis_tready=1 -> no m_axis_tvalid until 2 cycles after input tlast; 4 beats out with data/tstrb/tuser identical; pkt_count=1.
- Three back-to-back 8-beat packets, m_axis_tready=1 -> 24 contiguous output beats, no bubbles between packets; pkt_count=3.
- m_axis_tready=0 while 32 beats (four 8-beat packets) arrive -> s_axis_tready=0 after beat 32. Release tready -> all 32 beats out in order; s_axis_tready returns to 1.
- 40-beat packet, empty queue -> 40 beats accepted, no output, drop_count=1. A following 2-beat packet is forwarded intact; pkt_count=1.
- Exactly 32-beat packet -> committed and forwarded; drop_count=0.
- Random m_axis_tready (50%), alternating 1-beat and 5-beat packets, aresetn pulsed low mid-packet -> outputs clear immediately; after release, subsequent packets forward correctly with counts restarting from 0.

Source files
------------

// File: rtl/nf10_axis_pkt_out_queue.sv
// nf10_axis_pkt_out_queue
// Store-and-forward AXI4-Stream packet queue. Only fully received packets are
// exposed to the output side, so the sink never stalls mid-frame on the source.
// A packet that cannot fit in the beat store is swallowed and counted.
//
// Pointer roles:
//   wr_ptr        - next beat slot to write
//   pkt_start_ptr - first beat of the packet currently being received; every
//                   beat below it is committed and may be read
//   fetch_ptr     - next committed beat to pull into the output pipeline
//   rd_ptr        - release pointer; a slot is freed only when its beat has
//                   been handshaked on m_axis, so the two beats held in the
//                   output pipeline still count against capacity
module nf10_axis_pkt_out_queue #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_DEPTH_LOG2       = 5,
    parameter int C_PKTS_LOG2        = 4
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic [7:0]                      pkt_count,
    output logic [7:0]                      drop_count
);

    localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;
    localparam int DEPTH  = 1 << C_DEPTH_LOG2;
    localparam int PW     = C_DEPTH_LOG2 + 1;

    localparam logic [C_PKTS_LOG2-1:0] CMT_MAX = '1;

    typedef struct packed {
        logic                          last;
        logic [C_AXIS_TUSER_WIDTH-1:0] user;
        logic [STRB_W-1:0]             strb;
        logic [C_AXIS_DATA_WIDTH-1:0]  data;
    } beat_t;

    typedef enum logic {
        ACCEPT = 1'b0,
        DROP   = 1'b1
    } wr_state_t;

    // ------------------------------------------------------------------
    // Storage and pointers
    // ------------------------------------------------------------------
    beat_t                  mem [DEPTH];
    beat_t                  s_beat;

    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [PW-1:0]          fetch_ptr;
    logic [PW-1:0]          pkt_start_ptr;
    logic [C_PKTS_LOG2-1:0] committed;

    wr_state_t              state;
    wr_state_t              state_nxt;

    logic                   full;
    logic                   acc_rdy;
    logic                   wr_en;
    logic                   commit;
    logic                   rollback;

    // Output pipeline: s1 is the prefetch stage, out drives m_axis.
    beat_t                  s1_beat;
    beat_t                  out_beat;
    logic                   s1_vld;
    logic                   out_vld;

    logic                   rd_avail;
    logic                   m_hs;
    logic                   out_take;
    logic                   s1_take;
    logic                   fetch;
    logic                   pkt_release;

    assign s_beat = {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};

    // Occupancy is measured against the release pointer, MSB-compare rule.
    assign full = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                  (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------

    // Write FSM next-state and input handshake decode.
    always_comb begin
        state_nxt = state;
        acc_rdy   = 1'b0;
        wr_en     = 1'b0;
        commit    = 1'b0;
        rollback  = 1'b0;
        case (state)
            ACCEPT: begin
                // A tlast beat would overflow the committed counter, so it
                // waits until a packet drains out.
                acc_rdy = !full && !(s_axis_tlast && (committed == CMT_MAX));
                if (s_axis_tvalid && acc_rdy) begin
                    wr_en  = 1'b1;
                    commit = s_axis_tlast;
                end
                // The partial packet owns every slot and still has no tlast:
                // it can never complete, so switch to discarding it.
                if (full && (committed == '0))
                    state_nxt = DROP;
            end
            DROP: begin
                acc_rdy = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    rollback  = 1'b1;
                    state_nxt = ACCEPT;
                end
            end
            default: state_nxt = ACCEPT;
        endcase
    end

    // Ready is held low for as long as reset is asserted.
    assign s_axis_tready = acc_rdy && aresetn;

    // Write FSM state, write pointer, packet start and drop counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= ACCEPT;
            wr_ptr        <= '0;
            pkt_start_ptr <= '0;
            drop_count    <= '0;
        end else begin
            state <= state_nxt;
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (commit)
                pkt_start_ptr <= wr_ptr + 1'b1;
            if (rollback) begin
                wr_ptr     <= pkt_start_ptr;
                drop_count <= drop_count + 1'b1;
            end
        end
    end

    // Beat store write port; contents need no reset.
    always_ff @(posedge aclk) begin
        if (wr_en)
            mem[wr_ptr[PW-2:0]] <= s_beat;
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------

    // Beats below pkt_start_ptr belong to committed packets.
    assign rd_avail    = (fetch_ptr != pkt_start_ptr);
    assign m_hs        = out_vld && m_axis_tready;
    assign out_take    = !out_vld || m_axis_tready;
    assign s1_take     = !s1_vld || out_take;
    assign fetch       = s1_take && rd_avail;
    assign pkt_release = m_hs && out_beat.last;

    // Two-stage output pipeline: out only changes when empty or on handshake,
    // and s1 refills in the same cycle it hands over, giving 1 beat/cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_vld    <= 1'b0;
            out_vld   <= 1'b0;
            s1_beat   <= '0;
            out_beat  <= '0;
            fetch_ptr <= '0;
            rd_ptr    <= '0;
        end else begin
            if (out_take) begin
                out_vld  <= s1_vld;
                out_beat <= s1_beat;
            end
            if (s1_take) begin
                s1_vld <= rd_avail;
                if (rd_avail)
                    s1_beat <= mem[fetch_ptr[PW-2:0]];
            end
            if (fetch)
                fetch_ptr <= fetch_ptr + 1'b1;
            if (m_hs)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Committed-packet counter and forwarded-packet counter; a commit and a
    // release in the same cycle cancel out.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            committed <= '0;
            pkt_count <= '0;
        end else begin
            if (commit && !pkt_release)
                committed <= committed + 1'b1;
            else if (!commit && pkt_release)
                committed <= committed - 1'b1;
            if (pkt_release)
                pkt_count <= pkt_count + 1'b1;
        end
    end

    assign m_axis_tvalid = out_vld;
    assign m_axis_tdata  = out_beat.data;
    assign m_axis_tstrb  = out_beat.strb;
    assign m_axis_tuser  = out_beat.user;
    assign m_axis_tlast  = out_beat.last;

endmodule

// File: tb/tb_nf10_axis_pkt_out_queue.sv
// Directed testbench for nf10_axis_pkt_out_queue.
module tb_nf10_axis_pkt_out_queue;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int SW = DW / 8;

    typedef struct packed {
        logic          last;
        logic [UW-1:0] user;
        logic [SW-1:0] strb;
        logic [DW-1:0] data;
    } beat_t;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [DW-1:0] s_axis_tdata;
    logic [SW-1:0] s_axis_tstrb;
    logic [UW-1:0] s_axis_tuser;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic [SW-1:0] m_axis_tstrb;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [7:0]    pkt_count;
    logic [7:0]    drop_count;

    nf10_axis_pkt_out_queue dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .pkt_count     (pkt_count),
        .drop_count    (drop_count)
    );

    always #5 aclk = ~aclk;

    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned cyc = 0;

    beat_t       exp_q[$];
    beat_t       out_q[$];
    int unsigned out_edge[$];
    int unsigned s_last_edge = 0;
    int unsigned m_rise_cyc = 0;
    int          hold_err = 0;
    int          bubble_err = 0;
    logic        prev_stall = 1'b0;
    logic        prev_vld = 1'b0;
    logic        in_pkt = 1'b0;
    beat_t       prev_beat = '0;
    beat_t       m_cur;

    assign m_cur = {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata};

    // Edge counter: after the k-th rising edge cyc == k.
    always @(posedge aclk) cyc <= cyc + 1;

    // Output monitor on the falling edge: records handshakes, checks that a
    // stalled beat holds and that tvalid never drops inside a packet.
    always @(negedge aclk) begin
        if (!aresetn) begin
            prev_stall <= 1'b0;
            prev_vld   <= 1'b0;
            in_pkt     <= 1'b0;
        end else begin
            if (prev_stall && (m_axis_tvalid !== 1'b1 || m_cur !== prev_beat))
                hold_err <= hold_err + 1;
            if (in_pkt && !m_axis_tvalid)
                bubble_err <= bubble_err + 1;
            if (m_axis_tvalid && !prev_vld)
                m_rise_cyc <= cyc;
            if (m_axis_tvalid && m_axis_tready) begin
                out_q.push_back(m_cur);
                out_edge.push_back(cyc + 1);
                in_pkt <= !m_axis_tlast;
            end
            if (s_axis_tvalid && s_axis_tready && s_axis_tlast)
                s_last_edge <= cyc + 1;
            prev_stall <= m_axis_tvalid && !m_axis_tready;
            prev_vld   <= m_axis_tvalid;
            prev_beat  <= m_cur;
        end
    end

    function automatic beat_t mk_beat(input logic [7:0] pid, input logic [7:0] idx,
                                      input logic last);
        beat_t b;
        b.data = {16{pid, idx}};
        b.strb = {pid, idx, ~pid, ~idx};
        b.user = {8{idx, pid}};
        b.last = last;
        return b;
    endfunction

    // Present one beat and hold it until accepted (bounded).
    task automatic send_beat(input beat_t b);
        int w;
        s_axis_tdata  = b.data;
        s_axis_tstrb  = b.strb;
        s_axis_tuser  = b.user;
        s_axis_tlast  = b.last;
        s_axis_tvalid = 1'b1;
        w = 0;
        @(negedge aclk);
        while (!s_axis_tready && w < 100) begin
            @(negedge aclk);
            w++;
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] pid, input int len, input bit fwd);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b = mk_beat(pid, 8'(i), i == len - 1);
            if (fwd) exp_q.push_back(b);
            send_beat(b);
        end
    endtask

    task automatic wait_out(input int n);
        int w;
        w = 0;
        while (out_q.size() < n && w < 2000) begin
            @(negedge aclk);
            w++;
        end
        repeat (3) @(negedge aclk);
    endtask

    task automatic apply_reset();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        aresetn       = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
        s_axis_tuser  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        aresetn       = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_m_tvalid: got %b want 0", m_axis_tvalid); end
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL reset_s_tready: got %b want 0", s_axis_tready); end
        n_cmp++; if (pkt_count !== 8'd0) begin n_err++; $display("FAIL reset_pkt_count: got %0d want 0", pkt_count); end
        n_cmp++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
        aresetn = 1'b1;
        @(negedge aclk);
        n_cmp++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL post_reset_s_tready: got %b want 1", s_axis_tready); end
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL post_reset_m_tvalid: got %b want 0", m_axis_tvalid); end
    endtask

    task automatic test_single_pkt();
        int base;
        apply_reset();
        base = out_q.size();
        send_pkt(8'h01, 4, 1'b1);
        wait_out(base + 4);
        n_cmp++; if (m_rise_cyc !== s_last_edge + 2) begin n_err++; $display("FAIL single_latency: got edge %0d want %0d", m_rise_cyc, s_last_edge + 2); end
        n_cmp++; if (out_q.size() - base != exp_q.size()) begin n_err++; $display("FAIL single_beats: got %0d want %0d", out_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < out_q.size(); i++) begin
            n_cmp++; if (out_q[base+i] !== exp_q[i]) begin n_err++; $display("FAIL single_beat%0d: got %h want %h", i, out_q[base+i], exp_q[i]); end
        end
        n_cmp++; if (pkt_count !== 8'd1) begin n_err++; $display("FAIL single_pkt_count: got %0d want 1", pkt_count); end
    endtask

    task automatic test_back_to_back();
        int base;
        apply_reset();
        base = out_q.size();
        send_pkt(8'h02, 8, 1'b1);
        send_pkt(8'h03, 8, 1'b1);
        send_pkt(8'h04, 8, 1'b1);
        wait_out(base + 24);
        n_cmp++; if (out_q.size() - base != 24) begin n_err++; $display("FAIL b2b_beats: got %0d want 24", out_q.size() - base); end
        for (int i = 0; i < exp_q.size() && base + i < out_q.size(); i++) begin
            n_cmp++; if (out_q[base+i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_beat%0d: got %h want %h", i, out_q[base+i], exp_q[i]); end
        end
        for (int i = 1; i < 24 && base + i < out_edge.size(); i++) begin
            n_cmp++; if (out_edge[base+i] - out_edge[base+i-1] != 1) begin n_err++; $display("FAIL b2b_gap%0d: got %0d cycles want 1", i, out_edge[base+i] - out_edge[base+i-1]); end
        end
        n_cmp++; if (pkt_count !== 8'd3) begin n_err++; $display("FAIL b2b_pkt_count: got %0d want 3", pkt_count); end
    endtask

    task automatic test_backpressure();
        int base;
        int h0;
        apply_reset();
        base = out_q.size();
        h0 = hold_err;
        m_axis_tready = 1'b0;
        for (int p = 0; p < 4; p++) send_pkt(8'(8'h05 + p), 8, 1'b1);
        @(negedge aclk);
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready: got %b want 0", s_axis_tready); end
        repeat (4) @(negedge aclk);
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL bp_full_hold: got %b want 0", s_axis_tready); end
        n_cmp++; if (out_q.size() - base != 0) begin n_err++; $display("FAIL bp_no_output: got %0d want 0", out_q.size() - base); end
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b1;
        wait_out(base + 32);
        n_cmp++; if (out_q.size() - base != 32) begin n_err++; $display("FAIL bp_beats: got %0d want 32", out_q.size() - base); end
        for (int i = 0; i < exp_q.size() && base + i < out_q.size(); i++) begin
            n_cmp++; if (out_q[base+i] !== exp_q[i]) begin n_err++; $display("FAIL bp_beat%0d: got %h want %h", i, out_q[base+i], exp_q[i]); end
        end
        n_cmp++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back: got %b want 1", s_axis_tready); end
        n_cmp++; if (pkt_count !== 8'd4) begin n_err++; $display("FAIL bp_pkt_count: got %0d want 4", pkt_count); end
        n_cmp++; if (hold_err - h0 != 0) begin n_err++; $display("FAIL bp_stall_hold: got %0d unstable cycles want 0", hold_err - h0); end
    endtask

    task automatic test_oversize();
        int base;
        apply_reset();
        base = out_q.size();
        send_pkt(8'h09, 40, 1'b0);
        n_cmp++; if (out_q.size() - base != 0) begin n_err++; $display("FAIL drop_no_output: got %0d want 0", out_q.size() - base); end
        n_cmp++; if (drop_count !== 8'd1) begin n_err++; $display("FAIL drop_count: got %0d want 1", drop_count); end
        send_pkt(8'h0A, 2, 1'b1);
        wait_out(base + 2);
        n_cmp++; if (out_q.size() - base != 2) begin n_err++; $display("FAIL drop_next_beats: got %0d want 2", out_q.size() - base); end
        for (int i = 0; i < exp_q.size() && base + i < out_q.size(); i++) begin
            n_cmp++; if (out_q[base+i] !== exp_q[i]) begin n_err++; $display("FAIL drop_next_beat%0d: got %h want %h", i, out_q[base+i], exp_q[i]); end
        end
        n_cmp++; if (pkt_count !== 8'd1) begin n_err++; $display("FAIL drop_pkt_count: got %0d want 1", pkt_count); end
        n_cmp++; if (drop_count !== 8'd1) begin n_err++; $display("FAIL drop_count_after: got %0d want 1", drop_count); end
    endtask

    task automatic test_exact_fill();
        int base;
        apply_reset();
        base = out_q.size();
        send_pkt(8'h0B, 32, 1'b1);
        wait_out(base + 32);
        n_cmp++; if (out_q.size() - base != 32) begin n_err++; $display("FAIL fill_beats: got %0d want 32", out_q.size() - base); end
        for (int i = 0; i < exp_q.size() && base + i < out_q.size(); i++) begin
            n_cmp++; if (out_q[base+i] !== exp_q[i]) begin n_err++; $display("FAIL fill_beat%0d: got %h want %h", i, out_q[base+i], exp_q[i]); end
        end
        n_cmp++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL fill_drop_count: got %0d want 0", drop_count); end
        n_cmp++; if (pkt_count !== 8'd1) begin n_err++; $display("FAIL fill_pkt_count: got %0d want 1", pkt_count); end
    endtask

    task automatic test_random_reset();
        int base;
        int h0;
        int b0;
        bit stop;
        apply_reset();
        stop = 1'b0;
        fork
            begin
                while (!stop) begin
                    @(posedge aclk);
                    #1;
                    m_axis_tready = 1'($urandom_range(0, 1));
                end
            end
            begin
                base = out_q.size();
                send_pkt(8'h0C, 1, 1'b1);
                send_pkt(8'h0D, 5, 1'b1);
                wait_out(base + 6);
                n_cmp++; if (out_q.size() - base != 6) begin n_err++; $display("FAIL rnd_pre_beats: got %0d want 6", out_q.size() - base); end
                for (int i = 0; i < exp_q.size() && base + i < out_q.size(); i++) begin
                    n_cmp++; if (out_q[base+i] !== exp_q[i]) begin n_err++; $display("FAIL rnd_pre_beat%0d: got %h want %h", i, out_q[base+i], exp_q[i]); end
                end
                n_cmp++; if (pkt_count !== 8'd2) begin n_err++; $display("FAIL rnd_pre_pkt_count: got %0d want 2", pkt_count); end
                // Three beats of a packet that never finishes, then reset.
                for (int i = 0; i < 3; i++) send_beat(mk_beat(8'h0E, 8'(i), 1'b0));
                aresetn = 1'b0;
                #1;
                n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rnd_rst_m_tvalid: got %b want 0", m_axis_tvalid); end
                n_cmp++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL rnd_rst_s_tready: got %b want 0", s_axis_tready); end
                n_cmp++; if (pkt_count !== 8'd0) begin n_err++; $display("FAIL rnd_rst_pkt_count: got %0d want 0", pkt_count); end
                n_cmp++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL rnd_rst_drop_count: got %0d want 0", drop_count); end
                repeat (2) @(posedge aclk);
                #1;
                aresetn = 1'b1;
                exp_q.delete();
                base = out_q.size();
                h0 = hold_err;
                b0 = bubble_err;
                send_pkt(8'h0F, 1, 1'b1);
                send_pkt(8'h10, 5, 1'b1);
                send_pkt(8'h11, 1, 1'b1);
                send_pkt(8'h12, 5, 1'b1);
                wait_out(base + 12);
                n_cmp++; if (out_q.size() - base != 12) begin n_err++; $display("FAIL rnd_post_beats: got %0d want 12", out_q.size() - base); end
                for (int i = 0; i < exp_q.size() && base + i < out_q.size(); i++) begin
                    n_cmp++; if (out_q[base+i] !== exp_q[i]) begin n_err++; $display("FAIL rnd_post_beat%0d: got %h want %h", i, out_q[base+i], exp_q[i]); end
                end
                n_cmp++; if (pkt_count !== 8'd4) begin n_err++; $display("FAIL rnd_post_pkt_count: got %0d want 4", pkt_count); end
                n_cmp++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL rnd_post_drop_count: got %0d want 0", drop_count); end
                n_cmp++; if (hold_err - h0 != 0) begin n_err++; $display("FAIL rnd_stall_hold: got %0d unstable cycles want 0", hold_err - h0); end
                n_cmp++; if (bubble_err - b0 != 0) begin n_err++; $display("FAIL rnd_bubble: got %0d in-packet gaps want 0", bubble_err - b0); end
                stop = 1'b1;
            end
        join
        m_axis_tready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_pkt();
        test_back_to_back();
        test_backpressure();
        test_oversize();
        test_exact_fill();
        test_random_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
